// File: rtl/rom_load_ctrl_if.sv
// rtl/rom_load_ctrl_if.sv - byte stream and memory write port bundle for rom_load_ctrl
interface rom_load_ctrl_if #(
    parameter int DW = 32,
    parameter int AW = 12
);
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          wen;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;

    modport master (
        output byte_valid, byte_data,
        input  byte_ready, wen, w_addr, w_data
    );

    modport slave (
        input  byte_valid, byte_data,
        output byte_ready, wen, w_addr, w_data
    );
endinterface

// File: rtl/rom_load_ctrl.sv
// rtl/rom_load_ctrl.sv - framed byte-stream loader for the instruction memory write port
module rom_load_ctrl #(
    parameter int DW      = 32,
    parameter int AW      = 12,
    parameter int MEM_NUM = 4096,
    parameter int TMO_CYC = 1000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    rom_load_ctrl_if.slave  bif,
    output logic            cpu_hold,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [1:0]      err_code,
    output logic [AW:0]     words_loaded
);
    localparam int IW = $clog2(TMO_CYC + 1);

    typedef enum logic [2:0] {IDLE, LEN, DATA, CHK, DONE, ERR} state_t;

    state_t        state;
    logic [1:0]    byte_cnt;
    logic [31:0]   len_r;
    logic [DW-1:0] word_r;
    logic [7:0]    csum;
    logic [IW-1:0] idle_cnt;
    logic          take;
    logic [31:0]   len_next;
    logic [DW-1:0] word_next;
    logic [7:0]    csum_next;

    assign bif.byte_ready = (state == LEN) || (state == DATA) || (state == CHK);
    assign take           = bif.byte_valid && bif.byte_ready;
    // Shifting in from the top makes the first byte land in bits 7:0 after four bytes.
    assign len_next       = {bif.byte_data, len_r[31:8]};
    assign word_next      = {bif.byte_data, word_r[DW-1:8]};
    assign csum_next      = csum + bif.byte_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            byte_cnt     <= '0;
            len_r        <= '0;
            word_r       <= '0;
            csum         <= '0;
            idle_cnt     <= '0;
            bif.wen      <= 1'b0;
            bif.w_addr   <= '0;
            bif.w_data   <= '0;
            cpu_hold     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            err_code     <= 2'd0;
            words_loaded <= '0;
        end else begin
            bif.wen <= 1'b0;
            if (take)
                idle_cnt <= '0;
            else if (bif.byte_ready)
                idle_cnt <= idle_cnt + 1'b1;

            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state        <= LEN;
                        cpu_hold     <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        err          <= 1'b0;
                        err_code     <= 2'd0;
                        words_loaded <= '0;
                        byte_cnt     <= '0;
                        csum         <= '0;
                        idle_cnt     <= '0;
                    end
                end
                LEN: begin
                    if (take) begin
                        len_r    <= len_next;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            if (len_next == 32'd0 || len_next > 32'(MEM_NUM)) begin
                                state    <= ERR;
                                err      <= 1'b1;
                                err_code <= 2'd1;
                                busy     <= 1'b0;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    if (take) begin
                        word_r   <= word_next;
                        csum     <= csum_next;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            bif.wen      <= 1'b1;
                            bif.w_addr   <= words_loaded[AW-1:0];
                            bif.w_data   <= word_next;
                            words_loaded <= words_loaded + 1'b1;
                            if (words_loaded + 1'b1 == len_r[AW:0])
                                state <= CHK;
                        end
                    end
                end
                CHK: begin
                    if (take) begin
                        busy <= 1'b0;
                        if (csum_next == 8'd0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state    <= ERR;
                            err      <= 1'b1;
                            err_code <= 2'd2;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // A stalled source aborts the download; cpu_hold stays set so a partial image never runs.
            if (!take && bif.byte_ready && idle_cnt == IW'(TMO_CYC - 1)) begin
                state    <= ERR;
                err      <= 1'b1;
                err_code <= 2'd3;
                busy     <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_rom_load_ctrl.sv
// tb/tb_rom_load_ctrl.sv - randomized self-checking bench for rom_load_ctrl
module tb_rom_load_ctrl;
    localparam int AW      = 12;
    localparam int DW      = 32;
    localparam int MEM_NUM = 4096;
    localparam int TMO_CYC = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          cpu_hold, busy, done, err;
    logic [1:0]    err_code;
    logic [AW:0]   words_loaded;

    rom_load_ctrl_if #(.DW(DW), .AW(AW)) bif ();

    rom_load_ctrl #(.DW(DW), .AW(AW), .MEM_NUM(MEM_NUM), .TMO_CYC(TMO_CYC)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .bif          (bif),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .err_code     (err_code),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: the frame as a byte list and the writes/status it must produce.
    logic [7:0]          frame[$];
    logic [AW+DW-1:0]    exp_wr[$];
    logic [AW+DW-1:0]    mon_e;
    logic                exp_done, exp_err;
    logic [1:0]          exp_code;
    int                  exp_words;
    int                  send_len;

    always @(negedge clk) begin
        if (bif.wen) begin
            if (exp_wr.size() == 0) begin
                check_eq("wen_unexpected", bif.wen, 0);
            end else begin
                mon_e = exp_wr.pop_front();
                check_eq("w_addr", bif.w_addr, mon_e[AW+DW-1:DW]);
                check_eq("w_data", bif.w_data, mon_e[DW-1:0]);
                check_eq("wl_at_wen", words_loaded, mon_e[AW+DW-1:DW] + 1);
            end
        end
    end

    task automatic model_frame();
        logic [31:0] n;
        logic [31:0] word;
        int          sum;
        n = {frame[3], frame[2], frame[1], frame[0]};
        exp_wr.delete();
        if (n == 0 || n > 32'(MEM_NUM)) begin
            exp_done = 0; exp_err = 1; exp_code = 1; exp_words = 0; send_len = 4;
        end else begin
            sum = 0;
            for (int i = 0; i < int'(n); i++) begin
                word = {frame[4+4*i+3], frame[4+4*i+2], frame[4+4*i+1], frame[4+4*i]};
                exp_wr.push_back({AW'(i), word});
                for (int j = 0; j < 4; j++) sum += frame[4+4*i+j];
            end
            sum += frame[4+4*n];
            exp_words = int'(n);
            send_len  = 4 + 4*int'(n) + 1;
            if (sum % 256 == 0) begin
                exp_done = 1; exp_err = 0; exp_code = 0;
            end else begin
                exp_done = 0; exp_err = 1; exp_code = 2;
            end
        end
    endtask

    task automatic build_frame(input int kind, input int n);
        logic [31:0] len;
        logic [7:0]  sum, b;
        frame.delete();
        len = 32'(n);
        if (kind == 2) begin
            case ($urandom_range(0, 2))
                0:       len = 32'd0;
                1:       len = 32'(MEM_NUM + 1);
                default: len = 32'(MEM_NUM + 1) + ($urandom & 32'h7fff_ffff);
            endcase
        end
        for (int k = 0; k < 4; k++) frame.push_back(len[8*k +: 8]);
        if (kind != 2) begin
            sum = 8'd0;
            for (int i = 0; i < 4*n; i++) begin
                b = 8'($urandom);
                frame.push_back(b);
                sum += b;
            end
            b = 8'(8'd0 - sum);
            if (kind == 1) b = b + 8'($urandom_range(1, 255));
            frame.push_back(b);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("hold_on_start", cpu_hold, 1);
        check_eq("busy_on_start", busy, 1);
        check_eq("done_clr", done, 0);
        check_eq("err_clr", err, 0);
        check_eq("wl_clr", words_loaded, 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit with_start);
        bit acc;
        int waited;
        waited = 0;
        bif.byte_valid = 1'b1;
        bif.byte_data  = b;
        start          = with_start;
        do begin
            acc = bif.byte_ready;
            @(negedge clk);
            start = 1'b0;
            waited++;
        end while (!acc && waited < 64);
        check_eq("byte_accept", acc, 1);
    endtask

    task automatic send_bytes(input int cnt, input bit gaps, input bit mid_start);
        for (int i = 0; i < cnt; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) begin
                    bif.byte_valid = 1'b0;
                    bif.byte_data  = 8'($urandom);
                    @(negedge clk);
                end
            end
            send_byte(frame[i], mid_start && ($urandom_range(0, 3) == 0));
        end
        bif.byte_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input bit gaps, input bit mid_start);
        model_frame();
        pulse_start();
        send_bytes(send_len, gaps, mid_start);
        @(negedge clk);
        check_eq({tag, "_done"}, done, exp_done);
        check_eq({tag, "_err"}, err, exp_err);
        check_eq({tag, "_code"}, err_code, exp_code);
        check_eq({tag, "_words"}, words_loaded, exp_words);
        check_eq({tag, "_hold"}, cpu_hold, exp_err);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_ready"}, bif.byte_ready, 0);
        check_eq({tag, "_wr_left"}, exp_wr.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ready"}, bif.byte_ready, 0);
        check_eq({tag, "_wen"}, bif.wen, 0);
        check_eq({tag, "_waddr"}, bif.w_addr, 0);
        check_eq({tag, "_wdata"}, bif.w_data, 0);
        check_eq({tag, "_hold"}, cpu_hold, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_err"}, err, 0);
        check_eq({tag, "_code"}, err_code, 0);
        check_eq({tag, "_words"}, words_loaded, 0);
    endtask

    task automatic set_frame(input logic [7:0] b[$]);
        frame = b;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        start = 1'b0;
        bif.byte_valid = 1'b0;
        bif.byte_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b1;
        @(negedge clk);

        set_frame('{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                    8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hB4});
        run_frame("nominal", 0, 0);

        set_frame('{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                    8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hB5});
        run_frame("bad_csum", 0, 0);

        set_frame('{8'h00, 8'h00, 8'h00, 8'h00});
        run_frame("len_zero", 0, 0);

        set_frame('{8'h01, 8'h10, 8'h00, 8'h00});
        run_frame("len_4097", 0, 0);

        // Timeout: one word announced, two bytes delivered, then the source stalls.
        set_frame('{8'h01, 8'h00, 8'h00, 8'h00, 8'hAA, 8'h55});
        exp_wr.delete();
        pulse_start();
        send_bytes(6, 0, 0);
        repeat (TMO_CYC - 1) @(negedge clk);
        check_eq("tmo_early_err", err, 0);
        @(negedge clk);
        check_eq("tmo_err", err, 1);
        check_eq("tmo_code", err_code, 3);
        check_eq("tmo_ready", bif.byte_ready, 0);
        check_eq("tmo_hold", cpu_hold, 1);
        check_eq("tmo_words", words_loaded, 0);

        set_frame('{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
                    8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hB4});
        run_frame("gaps", 1, 1);

        // Reset after five data bytes: only the first word may have been written.
        model_frame();
        exp_wr = exp_wr[0:0];
        pulse_start();
        send_bytes(9, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        check_eq("rst_mid_wr_left", exp_wr.size(), 0);
        rst = 1'b1;
        @(negedge clk);
        run_frame("after_rst", 0, 0);

        for (int f = 0; f < 20; f++) begin
            build_frame($urandom_range(0, 2), $urandom_range(1, 8));
            run_frame("rand", $urandom_range(0, 1), $urandom_range(0, 1));
        end

        build_frame(0, MEM_NUM);
        run_frame("len_max", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
